// File: rtl/mopshub_pkg.sv
// Shared mopshub definitions: clock constants, arbiter FSM encoding and
// small helpers used by the timeout arbiter.
package mopshub_pkg;

  localparam int unsigned CLK_FREQ_HZ      = 40_000_000;
  // One millisecond worth of system clock cycles.
  localparam logic [31:0] DEF_LIMIT_CYCLES = 32'(CLK_FREQ_HZ / 1000);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRE  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A zero limit still yields a one-cycle window.
  function automatic logic [31:0] eff_limit(input logic [31:0] lim);
    return (lim == 32'd0) ? 32'd1 : lim;
  endfunction

endpackage

// File: rtl/timeout_arbiter_rr_select.sv
// Round-robin pick: the first requester after last_owner (modulo N_REQ)
// whose request bit is set, returned both one-hot and as an index.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [N_REQ-1:0] sel_onehot_o,
  output logic [IDX_W-1:0] sel_idx_o,
  output logic             sel_valid_o
);

  int cand;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sel_onehot_o = '0;
    sel_idx_o    = '0;
    sel_valid_o  = |req_i;
    cand         = 0;
    // Walk from farthest to nearest so the nearest match is the last write.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last_owner_i) + k) % N_REQ;
      if (req_i[IDX_W'(cand)]) begin
        sel_idx_o                  = IDX_W'(cand);
        sel_onehot_o               = '0;
        sel_onehot_o[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timeout_arbiter.sv
// Shared-timer bus arbiter: grants one requester a window of limit[owner]
// cycles and pulses timeout_rst to that requester if it overstays.
module timeout_arbiter
  import mopshub_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] DEF_LIMIT = DEF_LIMIT_CYCLES,
  localparam int         IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_sel,
  input  logic [31:0]      cfg_data,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [N_REQ-1:0] timeout_rst,
  output logic [15:0]      expire_cnt
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [31:0]      cur_limit_q, cur_limit_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      expire_cnt_q, expire_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] timeout_rst_q, timeout_rst_d;
  logic             busy_q, busy_d;
  logic [31:0]      limit_q [N_REQ];

  logic [N_REQ-1:0] rr_onehot;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_valid;
  logic             owner_release;
  logic             terminal;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .sel_onehot_o (rr_onehot),
    .sel_idx_o    (rr_idx),
    .sel_valid_o  (rr_valid)
  );

  // Only the current owner's bits matter; everyone else's done is ignored.
  assign owner_release = done[owner_q] | ~req[owner_q];
  assign terminal      = (cnt_q == cur_limit_q - 32'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rr_valid) state_d = ST_RUN;
      // Release beats terminal count so a finishing owner is never reset.
      ST_RUN: begin
        if (owner_release) state_d = ST_RELEASE;
        else if (terminal) state_d = ST_EXPIRE;
      end
      ST_EXPIRE:  state_d = ST_IDLE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d         = '0;
    timeout_rst_d = '0;
    busy_d        = 1'b0;
    case (state_d)
      ST_RUN: begin
        busy_d = 1'b1;
        gnt_d  = (state_q == ST_IDLE) ? rr_onehot : gnt_q;
      end
      ST_EXPIRE: timeout_rst_d = N_REQ'(1) << owner_q;
      default: ;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cur_limit_d  = cur_limit_q;
    cnt_d        = cnt_q;
    expire_cnt_d = expire_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          owner_d      = rr_idx;
          last_owner_d = rr_idx;
          cur_limit_d  = eff_limit(limit_q[rr_idx]);
          cnt_d        = '0;
        end
      end
      ST_RUN: begin
        if (!owner_release) begin
          if (terminal) expire_cnt_d = sat_inc16(expire_cnt_q);
          else          cnt_d        = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q       <= '0;
      last_owner_q  <= IDX_W'(N_REQ - 1);
      cur_limit_q   <= 32'd1;
      cnt_q         <= '0;
      expire_cnt_q  <= '0;
      gnt_q         <= '0;
      timeout_rst_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      cur_limit_q   <= cur_limit_d;
      cnt_q         <= cnt_d;
      expire_cnt_q  <= expire_cnt_d;
      gnt_q         <= gnt_d;
      timeout_rst_q <= timeout_rst_d;
      busy_q        <= busy_d;
    end
  end

  // NOTE: the limit registers are flops, not a RAM, so they take a reset
  // value; every window after reset then has a defined length.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) limit_q[i] <= DEF_LIMIT;
    end else if (cfg_we) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cfg_sel == IDX_W'(i)) limit_q[i] <= cfg_data;
      end
    end
  end

  assign gnt         = gnt_q;
  assign timeout_rst = timeout_rst_q;
  assign busy        = busy_q;
  assign expire_cnt  = expire_cnt_q;

endmodule

// File: tb/tb_timeout_arbiter.sv
// Directed bench for timeout_arbiter with a window-level reference model
// compared against the outputs every cycle.
module tb_timeout_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, done;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic [3:0]  gnt, timeout_rst;
  logic        busy;
  logic [15:0] expire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  timeout_arbiter #(.N_REQ(4), .DEF_LIMIT(32'd40000)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .gnt         (gnt),
    .busy        (busy),
    .timeout_rst (timeout_rst),
    .expire_cnt  (expire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks a grant window (owner, length, cycles used) and
  // the dead cycles after it, rather than FSM states.
  logic        m_valid = 1'b0;
  logic        m_active;
  int          m_owner, m_last, m_hold;
  logic [31:0] m_len, m_used;
  logic [31:0] m_limit [4];
  logic [15:0] m_exp;
  logic [3:0]  e_gnt, e_trst;
  logic        e_busy;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_hold   = 0;
      m_last   = 3;
      m_owner  = 0;
      m_exp    = '0;
      for (int i = 0; i < 4; i++) m_limit[i] = 32'd40000;
      e_gnt = '0; e_trst = '0; e_busy = 1'b0;
    end else if (m_valid) begin
      e_gnt = '0; e_trst = '0; e_busy = 1'b0;
      if (m_active) begin
        if (done[m_owner] || !req[m_owner]) begin
          m_active = 1'b0;
          m_hold   = 1;
        end else if (m_used == m_len) begin
          m_active = 1'b0;
          m_hold   = 1;
          e_trst   = 4'b0001 << m_owner;
          if (m_exp != 16'hFFFF) m_exp = m_exp + 16'd1;
        end else begin
          m_used = m_used + 32'd1;
          e_gnt  = 4'b0001 << m_owner;
          e_busy = 1'b1;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (!m_active && req[(m_last + k) % 4]) begin
            m_owner  = (m_last + k) % 4;
            m_active = 1'b1;
          end
        end
        m_len  = (m_limit[m_owner] == 32'd0) ? 32'd1 : m_limit[m_owner];
        m_used = 32'd1;
        m_last = m_owner;
        e_gnt  = 4'b0001 << m_owner;
        e_busy = 1'b1;
      end
      if (cfg_we) m_limit[cfg_sel] = cfg_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("timeout_rst", 32'(timeout_rst), 32'(e_trst));
      check("busy", 32'(busy), 32'(e_busy));
      check("expire_cnt", 32'(expire_cnt), 32'(m_exp));
    end
  end

  task automatic cfg_write(input int sel, input logic [31:0] val);
    cfg_we   = 1'b1;
    cfg_sel  = 2'(sel);
    cfg_data = val;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Waits for gnt[idx], counts its grant cycles, optionally pulses done on
  // grant cycle done_at and writes limit[idx]=cfg_val on grant cycle cfg_at.
  // The request is dropped when the window ends.
  task automatic run_window(input int idx, input int done_at, input int cfg_at,
                            input logic [31:0] cfg_val,
                            output int n_gnt, output logic [3:0] trst_end);
    int budget;
    budget   = 0;
    n_gnt    = 0;
    trst_end = '0;
    while (!gnt[idx] && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!gnt[idx]) begin
      check("grant_wait_timeout", 32'd0, 32'd1);
      req[idx] = 1'b0;
      return;
    end
    while (gnt[idx] && n_gnt < 300) begin
      n_gnt++;
      if (n_gnt == done_at) begin
        done[idx] = 1'b1;
        req[idx]  = 1'b0;
      end
      if (n_gnt == cfg_at) begin
        cfg_we   = 1'b1;
        cfg_sel  = 2'(idx);
        cfg_data = cfg_val;
      end
      @(negedge clk);
      done   = '0;
      cfg_we = 1'b0;
    end
    trst_end = timeout_rst;
    req[idx] = 1'b0;
  endtask

  int         n;
  logic [3:0] t;
  int         budget;
  int         got;
  int         exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = '0; done = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    repeat (3) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_trst", 32'(timeout_rst), 32'h0);
    check("reset_expire_cnt", 32'(expire_cnt), 32'h0);
    rst = 1'b0;

    // Ten-cycle window expires.
    cfg_write(1, 32'd10);
    req = 4'b0010;
    run_window(1, 0, 0, 32'd0, n, t);
    check("lim10_gnt_cycles", 32'(n), 32'd10);
    check("lim10_trst", 32'(t), 32'h2);
    check("lim10_expire_cnt", 32'(expire_cnt), 32'd1);
    repeat (3) @(negedge clk);

    // done on grant cycle 5 ends the window without an expiry.
    cfg_write(0, 32'd100);
    req = 4'b0001;
    run_window(0, 5, 0, 32'd0, n, t);
    check("done5_gnt_cycles", 32'(n), 32'd5);
    check("done5_trst", 32'(t), 32'h0);
    check("done5_expire_cnt", 32'(expire_cnt), 32'd1);
    repeat (3) @(negedge clk);

    // Round robin from a fresh reset with all limits at 3.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cfg_write(i, 32'd3);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      budget = 0;
      while (gnt == 4'b0000 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      got = -1;
      for (int b = 0; b < 4; b++) if (gnt[b]) got = b;
      check("rr_order", 32'(got), 32'(exp_order[g]));
      budget = 0;
      while (gnt != 4'b0000 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
    end
    req = 4'b0000;
    check("rr_expire_cnt", 32'(expire_cnt), 32'd5);
    repeat (3) @(negedge clk);

    // done coincides with terminal count; a mid-window limit write waits.
    cfg_write(2, 32'd5);
    req = 4'b0100;
    run_window(2, 5, 2, 32'd2, n, t);
    check("tc_done_gnt_cycles", 32'(n), 32'd5);
    check("tc_done_trst", 32'(t), 32'h0);
    check("tc_done_expire_cnt", 32'(expire_cnt), 32'd5);
    repeat (3) @(negedge clk);
    req = 4'b0100;
    run_window(2, 0, 0, 32'd0, n, t);
    check("newlim2_gnt_cycles", 32'(n), 32'd2);
    check("newlim2_trst", 32'(t), 32'h4);
    check("newlim2_expire_cnt", 32'(expire_cnt), 32'd6);
    repeat (3) @(negedge clk);

    // Reset in RUN cycle 3 drops the grant; requester 0 wins afterwards.
    cfg_write(1, 32'd20);
    req = 4'b0010;
    budget = 0;
    while (!gnt[1] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check("midrun_rst_gnt", 32'(gnt), 32'h0);
    check("midrun_rst_expire_cnt", 32'(expire_cnt), 32'h0);
    check("midrun_rst_trst", 32'(timeout_rst), 32'h0);
    rst = 1'b0;
    budget = 0;
    while (gnt == 4'b0000 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("post_rst_first_owner", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    // A zero limit behaves as a one-cycle window.
    cfg_write(3, 32'd0);
    req = 4'b1000;
    run_window(3, 0, 0, 32'd0, n, t);
    check("lim0_gnt_cycles", 32'(n), 32'd1);
    check("lim0_trst", 32'(t), 32'h8);
    check("lim0_expire_cnt", 32'(expire_cnt), 32'd1);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timeout_arbiter.md
TIMEOUT_ARBITER -- requirements
Module: timeout_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single timeout counter.
REQ-002 Parameter DEF_LIMIT, default 32'd40000 (1 ms at 40 MHz): reset value of every per-requester limit register.
REQ-003 clk  input  1  system clock; the block has one clock, 40 MHz nominal.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request for a timed bus window; level, held until granted and finished.
REQ-006 done  input  N_REQ  per-requester completion; a single-cycle pulse is sufficient, and only the owner's bit is honoured.
REQ-007 cfg_we  input  1  limit register write strobe.
REQ-008 cfg_sel  input  clog2(N_REQ)  limit register index.
REQ-009 cfg_data  input  32  limit value in clk cycles.
REQ-010 gnt  output  N_REQ  one-hot (or zero) grant.
REQ-011 busy  output  1  high while any grant is active.
REQ-012 timeout_rst  output  N_REQ  one-cycle reset pulse to the requester whose window expired.
REQ-013 expire_cnt  output  16  saturating count of expiries since reset.

Function
REQ-014 Each requester has a 32-bit limit register, written on cfg_we at cfg_sel; an out-of-range index is ignored.
REQ-015 FSM states: IDLE, RUN, EXPIRE, RELEASE.
REQ-016 IDLE: if req is nonzero, select the owner round-robin, starting at last_owner+1 modulo N_REQ.
REQ-016a IDLE (cont.): latch limit[owner] into cur_limit, clear the counter, and go to RUN.
REQ-016b IDLE (cont.): gnt[owner] asserts on the first RUN cycle, one cycle after req is sampled.
REQ-017 A cur_limit of 0 is treated as 1.
REQ-018 A limit write during RUN does not affect the active window; it applies at the next grant.
REQ-019 RUN: the counter increments by 1 each cycle, starting from 0 on the first RUN cycle.
REQ-020 RUN: done[owner] or req[owner] deasserted leads to RELEASE.
REQ-021 RUN: when the counter equals cur_limit-1 with no release condition, go to EXPIRE, so gnt is high for exactly cur_limit cycles.
REQ-022 Simultaneous release condition and terminal count: release wins, with no timeout_rst and no expire_cnt increment.
REQ-023 EXPIRE: gnt=0, timeout_rst[owner]=1 for exactly one cycle, expire_cnt increments (saturates at 16'hFFFF), and the next state is IDLE.
REQ-024 RELEASE: gnt=0 for one cycle (bus turnaround), then IDLE; the same requester cannot be re-granted earlier than 2 cycles after release.
REQ-025 done bits of non-owners and done in IDLE are ignored.
REQ-026 The counter never wraps; it is cleared on every grant.
REQ-027 busy is high in RUN only.
REQ-028 At most one gnt bit and at most one timeout_rst bit are high in any cycle, and they are never high together.
REQ-029 last_owner updates at every grant.

Reset
REQ-030 While rst=1, on the clock edge: FSM to IDLE, gnt=0, timeout_rst=0, busy=0, expire_cnt=0, counter=0.
REQ-030a Reset values (cont.): last_owner=N_REQ-1 so that requester 0 has first priority, and all limit registers=DEF_LIMIT.
REQ-031 Reset asserted mid-RUN drops gnt on the next edge and issues no timeout_rst.
REQ-032 All outputs are registered; the block has no asynchronous paths.

Structure
REQ-033 FSM state encoding, DEF_LIMIT and the 40 MHz cycle constant live in the shared mopshub package.
REQ-034 The round-robin selector is a sub-module, rr_select, taking req and last_owner and returning a one-hot selection plus an index.
REQ-035 Counter and compare logic stay inline.

Verification
REQ-036 Limit[1]=10, req=4'b0010 held with no done: gnt[1] is high for 10 cycles, timeout_rst[1] pulses on cycle 11, and expire_cnt=1.
REQ-037 Limit[0]=100, req[0] held, done[0] on grant cycle 5: gnt drops the next cycle, with no timeout_rst and expire_cnt unchanged.
REQ-038 req=4'b1111 held, all limits=3: grants occur in order 0,1,2,3,0 with one RELEASE or EXPIRE gap between them.
REQ-039 Limit[2]=5, done[2] coincident with terminal count: no timeout_rst; cfg write of limit[2]=2 during RUN leaves the active window at 5 cycles.
REQ-040 rst pulsed in RUN cycle 3: gnt=0 and expire_cnt=0 the next cycle, and after reset requester 0 wins first.
REQ-041 Limit=0: gnt is high for 1 cycle, then timeout_rst pulses.
